// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - Fetch/data arbiter for one single-ported memory
// Data beats fetch, nothing is pre-empted, and a watchdog aborts stuck accesses.
module mem_port_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, IF_DROP, DM_WAIT} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  wd_cnt;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        dm_req;
  logic        grant_dm;
  logic        grant_if;
  logic        timeout;

  // A requester whose valid is high this cycle has been served and is not re-granted.
  assign dm_req   = dm_rd | dm_wr;
  assign grant_dm = dm_req & ~dm_valid;
  assign grant_if = if_req & ~flush & ~if_valid;
  assign timeout  = ~mem_ack & (wd_cnt == TMO);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_dm)      state_nxt = DM_WAIT;
        else if (grant_if) state_nxt = IF_WAIT;
      end
      IF_WAIT: begin
        if (mem_ack || timeout) state_nxt = IDLE;
        else if (flush)         state_nxt = IF_DROP;
      end
      IF_DROP, DM_WAIT: begin
        if (mem_ack || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state != IDLE);
    mem_we    = req_we;
    mem_addr  = req_addr;
    mem_wdata = req_wdata;
    if_stall  = if_req & ~if_valid;
    dm_stall  = dm_req & ~dm_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_we    <= 1'b0;
      wd_cnt    <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            req_addr  <= dm_addr;
            req_wdata <= dm_wdata;
            req_we    <= dm_wr;
            wd_cnt    <= '0;
          end else if (grant_if) begin
            req_addr <= if_addr;
            req_we   <= 1'b0;
            wd_cnt   <= '0;
          end
        end
        IF_WAIT: begin
          if (mem_ack) begin
            if (!flush) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
          end else if (timeout) begin
            // A flush coinciding with the abort cancels the zero-data pulse too.
            err <= 1'b1;
            if (!flush) begin
              if_rdata <= '0;
              if_valid <= 1'b1;
            end
          end else if (flush) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        IF_DROP: begin
          if (timeout)       err    <= 1'b1;
          else if (!mem_ack) wd_cnt <= wd_cnt + 8'd1;
        end
        DM_WAIT: begin
          if (mem_ack) begin
            if (!req_we) dm_rdata <= mem_rdata;
            dm_valid <= 1'b1;
          end else if (timeout) begin
            err      <= 1'b1;
            dm_rdata <= '0;
            dm_valid <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-ported unified memory between two requesters in the 5-stage pipeline: the fetch stage (instruction reads) and the memory stage (loads/stores).
- Data accesses have priority; an in-flight access is never pre-empted.
- Generates the fetch-stage and memory-stage stall signals, and discards fetch responses invalidated by a taken branch/jump flush.
- A watchdog bounds every memory access.

## Interface
Parameters:
- TIMEOUT, 15, max cycles a request may wait for mem_ack before abort (1..255)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch stage requests instruction at if_addr
- if_addr  in  32  instruction address
- flush  in  1  branch/jump taken (PC_Src != 0); cancels fetch
- if_rdata  out  32  instruction, valid when if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  hold fetch stage
- dm_rd  in  1  load request
- dm_wr  in  1  store request (dm_rd and dm_wr never both 1)
- dm_addr  in  32  data address
- dm_wdata  in  32  store data
- dm_rdata  out  32  load data, valid when dm_valid
- dm_valid  out  1  one-cycle data completion pulse (loads and stores)
- dm_stall  out  1  hold memory stage and everything upstream
- mem_req  out  1  memory request, level
- mem_we  out  1  write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, single cycle
- err  out  1  sticky timeout flag

## Operation
- FSM states: IDLE, IF_WAIT, IF_DROP, DM_WAIT.
- A request is "consumed" in the cycle its valid pulse is high. The arbiter does not grant that requester in that cycle; the other requester may be granted.
- IDLE grant rules:
  - dm_rd|dm_wr, not consumed → register dm_addr/dm_wdata/we=dm_wr, go DM_WAIT.
  - else if_req & ~flush, not consumed → register if_addr, we=0, go IF_WAIT.
  - else stay in IDLE.
- mem_req = 1 in IF_WAIT, IF_DROP and DM_WAIT. mem_addr/mem_we/mem_wdata come from the registered request and are stable until the ack cycle inclusive.
- IF_WAIT & mem_ack & ~flush → if_rdata<=mem_rdata, if_valid<=1, go IDLE.
- IF_WAIT & flush (with or without mem_ack) → if ack is present, discard it and go IDLE; otherwise go IF_DROP.
- IF_DROP: hold the request. On mem_ack, discard the data, no if_valid, go IDLE. Further flush has no effect.
- DM_WAIT & mem_ack → dm_rdata<=mem_rdata (loads; stores leave dm_rdata unchanged), dm_valid<=1, go IDLE. flush is ignored.
- Non-preemptive: a data request arriving during IF_WAIT/IF_DROP waits. dm_stall stays high until its own dm_valid.
- if_stall = if_req & ~if_valid. dm_stall = (dm_rd|dm_wr) & ~dm_valid. Both are combinational from inputs and registered valids.
- Watchdog: an 8-bit counter clears on entry to any WAIT/DROP state and increments each cycle without mem_ack. If the counter equals TIMEOUT with no ack:
  - err<=1 (sticky until reset) and go IDLE.
  - From IF_WAIT, if_valid pulses with if_rdata=0.
  - From DM_WAIT, dm_valid pulses with dm_rdata=0.
  - From IF_DROP, nothing is pulsed.
- mem_ack outside WAIT/DROP states is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0. rst low asserts immediately and mem_req drops asynchronously. An access in flight is abandoned and its late ack is ignored.
- Minimum latency: request cycle 0 → mem_req cycle 1 → mem_ack cycle 1 → valid cycle 2.
- A zero-wait memory gives one completed access every 2 cycles.
- Back-to-back: in the valid cycle the other requester may be granted, so mem_req is low for exactly that cycle.
- Simultaneous if_req and data request in IDLE: data is granted and fetch waits at least until the cycle after dm_valid.
- Timeout abort is raised in the cycle after the counter reaches TIMEOUT, i.e. TIMEOUT+1 cycles after mem_req rises.

## Test plan
- Reset, then if_req=1 with if_addr=0x0, memory acks in the first mem_req cycle with 0x8C010004 → mem_req cycle 1, if_valid cycle 2 with if_rdata=0x8C010004, if_stall low in cycle 2.
- if_req and dm_rd (addr 0x100) together, memory acks after 3 wait cycles → the data access is issued first and dm_valid precedes any fetch mem_req. After dm_valid, the fetch is issued; dm_stall is high throughout until dm_valid.
- Fetch in IF_WAIT, flush pulsed in cycle 2, ack in cycle 4 with 0x12345678 → no if_valid, state IDLE in cycle 5, next if_req is granted normally.
- Flush and mem_ack in the same IF_WAIT cycle → response dropped, no if_valid.
- dm_wr with addr 0x200 and data 0xCAFEF00D → mem_we=1, mem_wdata=0xCAFEF00D, one dm_valid, no reissue of the store while dm_wr is still high in the valid cycle.
- Memory never acks, TIMEOUT=15 → err rises and if_valid pulses with rdata 0 at the abort point. err stays high; rst low mid-access clears err and mem_req immediately.
